// File: rtl/shift_word_receiver.sv
// Serial-in/parallel-out word receiver: collects framed serial bits into WIDTH-bit words
// and holds each finished word in a one-entry valid/ready buffer with sticky error flags.
module shift_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  input  logic             o_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic             complete;
  logic             ovr_set;
  logic             ferr_set;

  // A fresh word starts from zero so a restarted frame carries nothing of the discarded one.
  always_comb begin
    if (LSB_FIRST) begin
      shifted    = {sin, sr_q[WIDTH-1:1]};
      first_word = {sin, {(WIDTH-1){1'b0}}};
    end else begin
      shifted    = {sr_q[WIDTH-2:0], sin};
      first_word = {{(WIDTH-1){1'b0}}, sin};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    complete = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (sin_valid && frame_start) begin
          sr_d    = first_word;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid && frame_start) begin
          ferr_set = 1'b1;
          sr_d     = first_word;
          cnt_d    = CW'(1);
        end else if (sin_valid) begin
          sr_d = shifted;
          if (cnt_q == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer decisions use the pre-edge o_valid so a consume and a new word can overlap.
  always_comb begin
    o_d       = o_q;
    o_valid_d = o_valid_q;
    ovr_set   = 1'b0;
    if (complete) begin
      if (!o_valid_q || o_ready) begin
        o_d       = shifted;
        o_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (o_valid_q && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (clr_err) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (ovr_set)  overrun_d   = 1'b1;
    if (ferr_set) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      o_q         <= '0;
      o_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      o_q         <= o_d;
      o_valid_q   <= o_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o         = o_q;
  assign o_valid   = o_valid_q;
  assign busy      = (state_q == SHIFT);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_shift_word_receiver.sv
// Bench for shift_word_receiver: MSB-first and LSB-first instances share one stimulus stream
// and are compared every cycle against a bit-list reference model.
module tb_shift_word_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         sin, sin_valid, frame_start, o_ready, clr_err;
  logic [W-1:0] o_m, o_l;
  logic         ov_m, ov_l, busy_m, busy_l, orun_m, orun_l, ferr_m, ferr_l;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  bit           bits[$];
  bit           mv;
  bit [W-1:0]   mo_m, mo_l;
  bit           movr, mferr;

  always #5 clk = ~clk;

  shift_word_receiver #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .o_ready(o_ready), .clr_err(clr_err), .o(o_m), .o_valid(ov_m), .busy(busy_m),
    .overrun(orun_m), .frame_err(ferr_m));

  shift_word_receiver #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .o_ready(o_ready), .clr_err(clr_err), .o(o_l), .o_valid(ov_l), .busy(busy_l),
    .overrun(orun_l), .frame_err(ferr_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    mv = 0; mo_m = '0; mo_l = '0; movr = 0; mferr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".o_msb"},     32'(o_m),    32'(mo_m));
    chk({tag, ".o_lsb"},     32'(o_l),    32'(mo_l));
    chk({tag, ".vld_msb"},   32'(ov_m),   32'(mv));
    chk({tag, ".vld_lsb"},   32'(ov_l),   32'(mv));
    chk({tag, ".busy_msb"},  32'(busy_m), 32'(bits.size() > 0));
    chk({tag, ".busy_lsb"},  32'(busy_l), 32'(bits.size() > 0));
    chk({tag, ".ovr_msb"},   32'(orun_m), 32'(movr));
    chk({tag, ".ovr_lsb"},   32'(orun_l), 32'(movr));
    chk({tag, ".ferr_msb"},  32'(ferr_m), 32'(mferr));
    chk({tag, ".ferr_lsb"},  32'(ferr_l), 32'(mferr));
  endtask

  // One clock: model advances on the inputs present at the edge, outputs checked 1ns later.
  task automatic cycle(input string tag);
    bit         done;
    bit [W-1:0] wm, wl;
    bit         ovs, fes;
    @(posedge clk);
    done = 0; ovs = 0; fes = 0; wm = '0; wl = '0;
    if (sin_valid) begin
      if (frame_start) begin
        if (bits.size() > 0) fes = 1;
        bits.delete();
        bits.push_back(sin);
      end else if (bits.size() > 0) begin
        bits.push_back(sin);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits[i];
            wl[i]     = bits[i];
          end
          done = 1;
          bits.delete();
        end
      end
    end
    if (done) begin
      if (!mv || o_ready) begin
        mv = 1; mo_m = wm; mo_l = wl;
      end else begin
        ovs = 1;
      end
    end else if (mv && o_ready) begin
      mv = 0;
    end
    if (clr_err) begin movr = 0; mferr = 0; end
    if (ovs) movr = 1;
    if (fes) mferr = 1;
    #1;
    check_all(tag);
  endtask

  task automatic send(input bit b, input bit fs, input bit rdy, input string tag);
    sin = b; sin_valid = 1; frame_start = fs; o_ready = rdy;
    cycle(tag);
    sin_valid = 0; frame_start = 0;
  endtask

  task automatic idle(input int n, input bit rdy, input string tag);
    sin_valid = 0; frame_start = 0; o_ready = rdy;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic send_word(input bit [W-1:0] w, input bit rdy_last, input string tag);
    for (int i = 0; i < W; i++) send(w[W-1-i], i == 0, (i == W-1) ? rdy_last : 1'b0, tag);
    o_ready = 0;
  endtask

  initial begin
    reset = 1; sin = 0; sin_valid = 0; frame_start = 0; o_ready = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 0;

    // 1: 0,1,1,0 MSB-first -> 0110
    send_word(4'b0110, 1'b0, "t1");
    chk("t1.o", 32'(o_m), 32'h6);
    chk("t1.vld", 32'(ov_m), 32'h1);
    chk("t1.busy", 32'(busy_m), 32'h0);
    idle(1, 1'b1, "t1.drain");
    chk("t1.drained", 32'(ov_m), 32'h0);

    // 2: 1,0,0,0 with gaps between bits
    send(1, 1, 0, "t2"); idle(2, 0, "t2.gap");
    send(0, 0, 0, "t2"); idle(1, 0, "t2.gap");
    send(0, 0, 0, "t2"); idle(3, 0, "t2.gap");
    send(0, 0, 0, "t2");
    chk("t2.o_msb", 32'(o_m), 32'h8);
    chk("t2.o_lsb", 32'(o_l), 32'h1);
    idle(1, 1'b1, "t2.drain");

    // 3: overrun with buffer full, then clear
    send_word(4'b0110, 1'b0, "t3a");
    send_word(4'b1001, 1'b0, "t3b");
    chk("t3.o_held", 32'(o_m), 32'h6);
    chk("t3.ovr", 32'(orun_m), 32'h1);
    clr_err = 1; idle(1, 0, "t3.clr"); clr_err = 0;
    chk("t3.ovr_clr", 32'(orun_m), 32'h0);
    idle(1, 1'b1, "t3.drain");

    // 4: consume in the same cycle the next word completes
    send_word(4'b0110, 1'b0, "t4a");
    send_word(4'b1001, 1'b1, "t4b");
    chk("t4.o", 32'(o_m), 32'h9);
    chk("t4.vld", 32'(ov_m), 32'h1);
    chk("t4.ovr", 32'(orun_m), 32'h0);
    idle(1, 1'b1, "t4.drain");

    // 5: frame restart mid-word
    send(1, 1, 0, "t5"); send(0, 0, 0, "t5");
    send_word(4'b1111, 1'b0, "t5");
    chk("t5.ferr", 32'(ferr_m), 32'h1);
    chk("t5.o", 32'(o_m), 32'hF);
    clr_err = 1; idle(1, 1'b1, "t5.clr"); clr_err = 0;

    // 6: async reset between edges mid-word
    send(1, 1, 0, "t6"); send(1, 0, 0, "t6");
    #2 reset = 1;
    #1;
    model_reset();
    check_all("t6.async");
    chk("t6.busy0", 32'(busy_m), 32'h0);
    #2 reset = 0;
    send_word(4'b0110, 1'b0, "t6b");
    chk("t6.o", 32'(o_m), 32'h6);
    chk("t6.ferr", 32'(ferr_m), 32'h0);
    chk("t6.ovr", 32'(orun_m), 32'h0);
    idle(1, 1'b1, "t6.drain");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sin         = 1'($urandom);
      sin_valid   = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 5) == 0);
      o_ready     = ($urandom_range(0, 2) == 0);
      clr_err     = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    sin_valid = 0; frame_start = 0; clr_err = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
